// File: rtl/sic_dispatch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// sic_dispatch_buffer_pkg
//   Shared types for the SIC dispatch buffer and its sub-units.
//   - sic_packet_t : packet handed from issue to the SIC sub-units
//   - sic_class_e  : instruction class carried in sic_packet_t.info
//   - SUB_IMM/SUB_ALU/SUB_BR/SUB_MEM : sub-unit indices
//   - sic_route()  : maps a packet class to its sub-unit index.
//                    Unknown classes fall back to SUB_IMM.
// -----------------------------------------------------------------------------
package sic_dispatch_buffer_pkg;

  localparam int NUM_PHY_REGS = 64;
  localparam int ID_WIDTH     = 8;
  localparam int NUM_ECRS     = 4;
  localparam int NUM_SUBS     = 4;

  localparam int SUB_IMM = 0;
  localparam int SUB_ALU = 1;
  localparam int SUB_BR  = 2;
  localparam int SUB_MEM = 3;

  localparam int SUB_IDX_W = $clog2(NUM_SUBS);
  typedef logic [SUB_IDX_W-1:0] sub_idx_t;

  typedef enum logic [2:0] {
    CLS_LUI   = 3'd0,
    CLS_ALU   = 3'd1,
    CLS_BR    = 3'd2,
    CLS_MEM   = 3'd3,
    CLS_AUIPC = 3'd4
  } sic_class_e;

  typedef struct packed {
    logic                            valid;
    logic [ID_WIDTH-1:0]             id;
    logic [2:0]                      info;  // sic_class_e encoding; 5..7 unused
    logic [$clog2(NUM_PHY_REGS)-1:0] prd;
    logic [$clog2(NUM_ECRS)-1:0]     ecr;
  } sic_packet_t;

  function automatic sub_idx_t sic_route(input logic [2:0] info);
    case (sic_class_e'(info))
      CLS_ALU:            return sub_idx_t'(SUB_ALU);
      CLS_BR:             return sub_idx_t'(SUB_BR);
      CLS_MEM:            return sub_idx_t'(SUB_MEM);
      CLS_LUI, CLS_AUIPC: return sub_idx_t'(SUB_IMM);
      default:            return sub_idx_t'(SUB_IMM);
    endcase
  endfunction

endpackage

// File: rtl/sic_dispatch_buffer_if.sv
// -----------------------------------------------------------------------------
// sic_dispatch_buffer_if
//   Issue-side and sub-unit-side signals of the dispatch buffer.
//   master : issue/sub-unit side (drives flush, in_pkt, sub_req)
//   slave  : dispatch buffer (drives in_ready, sub_pkt, count)
//   flush    : squash buffered packets and pending sub pulses
//   in_pkt   : packet from issue, in_pkt.valid = request
//   in_ready : buffer accepts in_pkt this cycle
//   sub_req  : req_instr from each sub-unit
//   sub_pkt  : registered packet to each sub-unit (valid is a 1-cycle pulse)
//   count    : FIFO occupancy
// -----------------------------------------------------------------------------
interface sic_dispatch_buffer_if #(
  parameter int DEPTH = 4
) ();
  import sic_dispatch_buffer_pkg::*;

  logic                               flush;
  sic_packet_t                        in_pkt;
  logic                               in_ready;
  logic [NUM_SUBS-1:0]                sub_req;
  sic_packet_t [NUM_SUBS-1:0]         sub_pkt;
  logic [$clog2(DEPTH):0]             count;

  modport master (output flush, in_pkt, sub_req, input in_ready, sub_pkt, count);
  modport slave  (input flush, in_pkt, sub_req, output in_ready, sub_pkt, count);

endinterface

// File: rtl/sic_dispatch_buffer_fifo.sv
// -----------------------------------------------------------------------------
// sic_pkt_fifo
//   In-order packet FIFO used by sic_dispatch_buffer. DEPTH must be a power of
//   two (>= 2) so the pointers wrap naturally.
//   clk, rst_n : clock, async active-low reset
//   push/din   : write din at the tail (ignored when full without a pop)
//   pop        : drop the head (ignored when empty)
//   flush      : next edge empties the FIFO; a same-cycle push is discarded
//   head       : current head entry (stale when empty)
//   count      : occupancy, full / empty : status flags
// -----------------------------------------------------------------------------
module sic_pkt_fifo
  import sic_dispatch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type pkt_t = sic_packet_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  pkt_t                   din,
  output pkt_t                   head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  pkt_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers define which
  // entries are live, so resetting the array would only cost area and timing.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sic_dispatch_buffer.sv
// -----------------------------------------------------------------------------
// sic_dispatch_buffer
//   In-order buffer/router between issue and the SIC sub-units (imm, alu,
//   branch, mem). Packets queue in sic_pkt_fifo; the head is sent to
//   sub_pkt[sic_route(head.info)] when that sub-unit requests and its
//   previous pulse has ended. sub_pkt registers break the comb path from
//   a sub-unit's req_instr back to its packet input.
//   clk, rst_n : clock, async active-low reset
//   bus        : sic_dispatch_buffer_if.slave (flush, in_pkt, in_ready,
//                sub_req, sub_pkt, count)
//   Optional feature: define SIC_DISPATCH_BYPASS_EN to let a packet arriving
//   at an empty FIFO go straight to its sub-unit on the accepting edge.
// -----------------------------------------------------------------------------
module sic_dispatch_buffer
  import sic_dispatch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sic_dispatch_buffer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  sic_packet_t                head;
  logic [CW-1:0]              fifo_count;
  logic                       fifo_full, fifo_empty;
  logic                       push, pop;
  sub_idx_t                   head_tgt;
  logic                       dispatch_fire, bypass_fire;
  sic_packet_t [NUM_SUBS-1:0] sub_pkt_d, sub_pkt_q;
`ifdef SIC_DISPATCH_BYPASS_EN
  sub_idx_t                   in_tgt;
`endif

  sic_pkt_fifo #(.DEPTH(DEPTH), .pkt_t(sic_packet_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .din   (bus.in_pkt),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    head_tgt = sic_route(head.info);
    // A sub-unit still showing last cycle's pulse cannot take another packet,
    // which keeps each sub_pkt[i].valid a single-cycle pulse.
    dispatch_fire = !fifo_empty && bus.sub_req[head_tgt]
                    && !sub_pkt_q[head_tgt].valid && !bus.flush;
`ifdef SIC_DISPATCH_BYPASS_EN
    in_tgt      = sic_route(bus.in_pkt.info);
    // Requires an empty FIFO, so it is mutually exclusive with dispatch_fire.
    bypass_fire = fifo_empty && bus.in_pkt.valid && bus.sub_req[in_tgt]
                  && !sub_pkt_q[in_tgt].valid && !bus.flush;
`else
    bypass_fire = 1'b0;
`endif
    // Popping the head frees a slot this cycle; flush empties everything.
    bus.in_ready = !fifo_full || dispatch_fire || bus.flush;
    push = bus.in_pkt.valid && bus.in_ready && !bus.flush && !bypass_fire;
    pop  = dispatch_fire;

    for (int i = 0; i < NUM_SUBS; i++) begin
      sub_pkt_d[i]       = sub_pkt_q[i];
      sub_pkt_d[i].valid = 1'b0;
    end
    if (dispatch_fire) begin
      sub_pkt_d[head_tgt]       = head;
      sub_pkt_d[head_tgt].valid = 1'b1;
    end
`ifdef SIC_DISPATCH_BYPASS_EN
    if (bypass_fire) begin
      sub_pkt_d[in_tgt]       = bus.in_pkt;
      sub_pkt_d[in_tgt].valid = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sub_pkt_q <= '0;
    else        sub_pkt_q <= sub_pkt_d;
  end

  assign bus.sub_pkt = sub_pkt_q;
  assign bus.count   = fifo_count;

endmodule

// File: tb/tb_sic_dispatch_buffer.sv
// -----------------------------------------------------------------------------
// tb_sic_dispatch_buffer
//   Directed scenarios followed by a randomized stream. The driver keeps a
//   queue model of the buffer (program-order list of accepted packets) and
//   pushes each expected dispatch onto a scoreboard; an independent monitor
//   pops and compares whenever a sub_pkt pulse appears. Honours
//   SIC_DISPATCH_BYPASS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_sic_dispatch_buffer;
  import sic_dispatch_buffer_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    int          tgt;
    sic_packet_t pkt;
  } disp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sic_dispatch_buffer_if #(.DEPTH(DEPTH)) bus ();

  sic_dispatch_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_disp = 0;
  sic_packet_t model_q[$];   // packets held in the buffer, program order
  disp_t       sb_q[$];      // dispatches expected at the next edge
  logic [3:0]  exp_busy;     // sub-units showing a pulse right now
  sic_packet_t cur_pkt;      // packet currently offered by issue
  bit          held;         // cur_pkt was refused and must be re-offered
  int          next_id = 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Class -> sub-unit table: alu=1, br=2, mem=3, everything else to imm (0).
  function automatic int ref_route(input logic [2:0] info);
    case (info)
      3'd1:    return 1;
      3'd2:    return 2;
      3'd3:    return 3;
      default: return 0;
    endcase
  endfunction

  // Monitor: compares every sub_pkt pulse against the scoreboard, and the
  // occupancy against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      int nv;
      int vi;
      nv = 0;
      vi = 0;
      for (int i = 0; i < NUM_SUBS; i++)
        if (bus.sub_pkt[i].valid) begin
          nv++;
          vi = i;
        end
      check("dispatch_count", nv, sb_q.size());
      if (sb_q.size() > 0) begin
        disp_t e;
        e = sb_q.pop_front();
        if (nv == 1) begin
          n_disp++;
          check("dispatch_tgt", vi, e.tgt);
          check("dispatch_id", int'(bus.sub_pkt[vi].id), int'(e.pkt.id));
          check("dispatch_info", int'(bus.sub_pkt[vi].info), int'(e.pkt.info));
          check("dispatch_prd", int'(bus.sub_pkt[vi].prd), int'(e.pkt.prd));
          check("dispatch_ecr", int'(bus.sub_pkt[vi].ecr), int'(e.pkt.ecr));
        end
      end
      check("count", int'(bus.count), model_q.size());
    end
  end

  // One issue cycle, entered and left at a falling edge.
  task automatic step(input bit v_in, input logic [2:0] cls,
                      input logic [3:0] req, input bit fl);
    int          sz, t;
    bit          v, fire, byp, exp_rdy, acc;
    sic_packet_t fpkt;
    v = v_in || held;
    if (v && !held) begin
      cur_pkt       = '0;
      cur_pkt.valid = 1'b1;
      cur_pkt.id    = next_id[7:0];
      cur_pkt.info  = cls;
      cur_pkt.prd   = 6'($urandom);
      cur_pkt.ecr   = 2'($urandom);
      next_id++;
    end
    bus.in_pkt  = v ? cur_pkt : '0;
    bus.sub_req = req;
    bus.flush   = fl;
    #1;
    sz   = model_q.size();
    fire = 1'b0;
    byp  = 1'b0;
    fpkt = '0;
    t    = 0;
    if (!fl && sz > 0) begin
      t = ref_route(model_q[0].info);
      if (req[t] && !exp_busy[t]) begin
        fire = 1'b1;
        fpkt = model_q.pop_front();
      end
    end
`ifdef SIC_DISPATCH_BYPASS_EN
    if (!fl && sz == 0 && v) begin
      t = ref_route(cur_pkt.info);
      if (req[t] && !exp_busy[t]) begin
        fire = 1'b1;
        byp  = 1'b1;
        fpkt = cur_pkt;
      end
    end
`endif
    exp_rdy = (sz != DEPTH) || fire || fl;
    check("in_ready", int'(bus.in_ready), int'(exp_rdy));
    acc = v && exp_rdy;
    if (fl) model_q.delete();
    else if (acc && !byp) model_q.push_back(cur_pkt);
    held     = v && !exp_rdy;
    exp_busy = '0;
    if (fire) begin
      fpkt.valid  = 1'b1;
      exp_busy[t] = 1'b1;
      sb_q.push_back('{t, fpkt});
    end
    @(negedge clk);
  endtask

  task automatic clear_model();
    model_q.delete();
    sb_q.delete();
    exp_busy = '0;
    held     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, int'(bus.count), 0);
    check({tag, "_in_ready"}, int'(bus.in_ready), 1);
    for (int i = 0; i < NUM_SUBS; i++)
      check({tag, "_sub_pkt"}, int'(bus.sub_pkt[i]), 0);
  endtask

  task automatic idle(input int n, input logic [3:0] req);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, req, 1'b0);
  endtask

  initial begin
    int d0;
    rst_n       = 1'b0;
    bus.in_pkt  = '0;
    bus.sub_req = '0;
    bus.flush   = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;
    @(negedge clk);

    // 1: single LUI with sub 0 requesting.
    d0 = n_disp;
    step(1'b1, 3'd0, 4'b0001, 1'b0);
    idle(3, 4'b0001);
    check("t1_dispatches", n_disp - d0, 1);

    // 2: fill with no requests; a fifth packet waits, then enters as the head fires.
    for (int i = 0; i < 4; i++) step(1'b1, 3'd1, 4'b0000, 1'b0);
    check("t2_full_count", int'(bus.count), 4);
    step(1'b1, 3'd2, 4'b0000, 1'b0);
    step(1'b1, 3'd2, 4'b0000, 1'b0);
    step(1'b1, 3'd2, 4'b0010, 1'b0);
    idle(12, 4'b1111);

    // 3: blocked head stalls a younger packet for an idle sub-unit.
    step(1'b1, 3'd2, 4'b0000, 1'b0);
    step(1'b1, 3'd1, 4'b0000, 1'b0);
    d0 = n_disp;
    idle(3, 4'b0010);
    check("t3_stalled", n_disp - d0, 0);
    idle(4, 4'b0110);
    check("t3_released", n_disp - d0, 2);

    // 4: flush with three buffered and a push in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 3'd3, 4'b0000, 1'b0);
    d0 = n_disp;
    step(1'b1, 3'd3, 4'b0000, 1'b1);
    check("t4_count_after_flush", int'(bus.count), 0);
    idle(3, 4'b1111);
    check("t4_no_pulse", n_disp - d0, 0);

    // 5: alternating subs 0/1, both requesting; ids must come out in order.
    d0 = n_disp;
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? 3'd0 : 3'd1, 4'b0011, 1'b0);
    idle(6, 4'b0011);
    check("t5_dispatches", n_disp - d0, 8);

    // 6: asynchronous reset mid-stream with two buffered packets.
    step(1'b1, 3'd1, 4'b0000, 1'b0);
    step(1'b1, 3'd1, 4'b0000, 1'b0);
    check("t6_count_before", int'(bus.count), 2);
    #2 rst_n = 1'b0;
    bus.in_pkt = '0;
    clear_model();
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    d0 = n_disp;
    step(1'b1, 3'd3, 4'b1000, 1'b0);
    idle(3, 4'b1000);
    check("t6_after_reset", n_disp - d0, 1);

    // Randomized stream with occasional flushes; refused packets are held.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom), 4'($urandom),
           $urandom_range(0, 29) == 0);
    idle(12, 4'b1111);
    check("final_model_empty", model_q.size(), 0);
    check("final_count", int'(bus.count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
